// File: rtl/mux2t1_64_arbiter.sv
// Round-robin arbiter for two valid/ready requesters feeding a 64-bit 2:1 mux into a one-word output register.
// Latency: a word accepted at edge N is on o/o_valid after edge N; a new word can load every cycle.
// Backpressure: o_ready=0 with o_valid=1 freezes the output stage and drops both requester readies.
module mux2t1_64_arbiter #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] I0,
  input  logic             I0_valid,
  output logic             I0_ready,
  input  logic [WIDTH-1:0] I1,
  input  logic             I1_valid,
  output logic             I1_ready,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             s,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic [WIDTH-1:0] r_o;
  logic             r_o_valid;
  logic             r_s;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_load;
  logic             w_gnt_vld;
  logic             w_gnt;
  logic [WIDTH-1:0] w_dat;

  // Grant selection: a lone requester wins outright, a tie goes to the one not served last.
  // Readies are held low while reset is asserted so no requester sees a handshake that
  // the (reset-held) registers never capture.
  always_comb begin
    w_load    = rst_n & (~r_o_valid | o_ready);
    w_gnt_vld = I0_valid | I1_valid;
    w_gnt     = (I0_valid & I1_valid) ? ~r_last : I1_valid;
    w_dat     = w_gnt ? I1 : I0;
    I0_ready  = w_load & w_gnt_vld & ~w_gnt;
    I1_ready  = w_load & w_gnt_vld & w_gnt;
  end

  // Output stage, grant pointer and per-requester transfer counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o       <= '0;
      r_o_valid <= 1'b0;
      r_s       <= 1'b0;
      r_last    <= 1'b1;
      r_cnt0    <= '0;
      r_cnt1    <= '0;
    end else if (w_load) begin
      if (w_gnt_vld) begin
        r_o       <= w_dat;
        r_o_valid <= 1'b1;
        r_s       <= w_gnt;
        r_last    <= w_gnt;
        if (w_gnt) begin
          r_cnt1 <= r_cnt1 + CNT_W'(1);
        end else begin
          r_cnt0 <= r_cnt0 + CNT_W'(1);
        end
      end else begin
        r_o_valid <= 1'b0;
      end
    end
  end

  assign o       = r_o;
  assign o_valid = r_o_valid;
  assign s       = r_s;
  assign cnt0    = r_cnt0;
  assign cnt1    = r_cnt1;

endmodule
